// File: rtl/result_mem_scheduler.sv
// Round-robin arbiter for the 8-bit result segment port, with a sequenced bulk clear.
// Every output is a register; the request inputs only reach the outputs through the FSM.
module result_mem_scheduler #(
  parameter int NREQ  = 3,
  parameter int AW    = 7,
  parameter int DW    = 8,
  parameter int DEPTH = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               err,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CLEAR = 2'd2} state_t;

  state_t         state_r;
  logic [IW-1:0]  rr_r;
  logic           rr_init_r;   // set until the first grant: search then starts at index 0
  logic           clr_pend_r;
  logic           acc_we_r;
  logic [AW-1:0]  cnt_r;

  logic           found_s;
  logic [IW-1:0]  win_s;
  logic [NREQ-1:0] onehot_s;
  logic [AW-1:0]  win_addr_s;
  logic [DW-1:0]  win_wdata_s;
  logic           win_we_s;
  logic           in_range_s;
  int             start_s;
  int             idx_s;

  // Round-robin winner search starting just after the last granted requester
  always_comb begin
    found_s     = 1'b0;
    win_s       = '0;
    onehot_s    = '0;
    idx_s       = 0;
    start_s     = rr_init_r ? 0 : int'(rr_r) + 1;
    if (start_s >= NREQ) begin
      start_s = 0;
    end else begin
      start_s = start_s;
    end
    for (int k = 0; k < NREQ; k++) begin
      idx_s = start_s + k;
      if (idx_s >= NREQ) begin
        idx_s = idx_s - NREQ;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = IW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      onehot_s[i] = found_s && (win_s == IW'(i));
    end
    win_addr_s  = req_addr[int'(win_s)*AW +: AW];
    win_wdata_s = req_wdata[int'(win_s)*DW +: DW];
    win_we_s    = req_we[win_s];
    in_range_s  = ({1'b0, win_addr_s} < DEPTH_W);
  end

  // Scheduler FSM with all segment-facing and requester-facing outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_r       <= '0;
      rr_init_r  <= 1'b1;
      clr_pend_r <= 1'b0;
      acc_we_r   <= 1'b0;
      cnt_r      <= '0;
      gnt        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt      <= '0;
      rvalid   <= '0;
      err      <= 1'b0;
      clr_done <= 1'b0;
      mem_we   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr_pend_r || clr_start) begin
            state_r    <= CLEAR;
            clr_pend_r <= 1'b0;
            cnt_r      <= '0;
            clr_busy   <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
          end else if (found_s) begin
            state_r   <= ACCESS;
            gnt       <= onehot_s;
            rr_r      <= win_s;
            rr_init_r <= 1'b0;
            acc_we_r  <= win_we_s;
            mem_addr  <= win_addr_s;
            mem_wdata <= win_wdata_s;
            mem_we    <= win_we_s & in_range_s;
            err       <= ~in_range_s;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r <= IDLE;
          if (clr_start) begin
            clr_pend_r <= 1'b1;
          end else begin
            clr_pend_r <= clr_pend_r;
          end
          // err is still high for an out-of-range access here, forcing the read to 0
          if (!acc_we_r) begin
            rvalid <= gnt;
            rdata  <= err ? '0 : mem_rdata;
          end else begin
            rdata <= rdata;
          end
        end
        CLEAR: begin
          mem_wdata <= '0;
          if (cnt_r == LAST_A) begin
            state_r  <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt_r    <= cnt_r + 1'b1;
            mem_addr <= cnt_r + 1'b1;
            mem_we   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
